// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a registered-read RAM: pointer/count bookkeeping, RAM port
// drive, and a 2-entry skid that hides the one-cycle read latency from the consumer.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                    Clock,
    input  logic                    iReset_n,
    input  logic                    iPushValid,
    input  logic [DATA_WIDTH-1:0]   iPushData,
    output logic                    oPushReady,
    output logic                    oPopValid,
    output logic [DATA_WIDTH-1:0]   oPopData,
    input  logic                    iPopReady,
    output logic                    oRamWriteEnable,
    output logic [ADDR_WIDTH-1:0]   oRamWriteAddress,
    output logic [DATA_WIDTH-1:0]   oRamDataIn,
    output logic [ADDR_WIDTH-1:0]   oRamReadAddress,
    input  logic [DATA_WIDTH-1:0]   iRamDataOut,
    output logic [ADDR_WIDTH+1:0]   oCount,
    output logic                    oOverflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (p == LAST_PTR) begin
            return ADDR_WIDTH'(1'b0);
        end else begin
            return p + ADDR_WIDTH'(1'b1);
        end
    endfunction

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   ram_cnt_r;
    logic                  inflight_r;
    logic [1:0]            skid_count_r;
    logic [DATA_WIDTH-1:0] skid0_r;
    logic [DATA_WIDTH-1:0] skid1_r;
    logic                  overflow_r;

    logic                  push_ready_s;
    logic                  push_fire_s;
    logic                  pop_valid_s;
    logic                  pop_fire_s;
    logic [2:0]            occ_s;
    logic                  issue_s;
    logic [ADDR_WIDTH:0]   ram_cnt_n_s;
    logic [1:0]            skid_count_n_s;
    logic [DATA_WIDTH-1:0] skid0_n_s;
    logic [DATA_WIDTH-1:0] skid1_n_s;

    // Handshake, read-issue decision and RAM-count update.
    always_comb begin
        push_ready_s = iReset_n && (ram_cnt_r != FULL_CNT);
        push_fire_s  = iPushValid && push_ready_s;
        pop_valid_s  = (skid_count_r != 2'd0);
        pop_fire_s   = pop_valid_s && iPopReady;
        occ_s        = {1'b0, skid_count_r} + {2'b00, inflight_r};
        // Only committed writes are counted, so a read never hits a same-cycle write slot.
        issue_s      = (ram_cnt_r != (ADDR_WIDTH + 1)'(1'b0)) &&
                       ((occ_s - {2'b00, pop_fire_s}) < 3'd2);
        ram_cnt_n_s  = ram_cnt_r + {{ADDR_WIDTH{1'b0}}, push_fire_s}
                                 - {{ADDR_WIDTH{1'b0}}, issue_s};
    end

    // Skid next state: the same-cycle pop is taken before the returning RAM word lands.
    always_comb begin
        skid0_n_s      = skid0_r;
        skid1_n_s      = skid1_r;
        skid_count_n_s = skid_count_r;
        case ({pop_fire_s, inflight_r})
            2'b10: begin
                skid0_n_s      = skid1_r;
                skid_count_n_s = skid_count_r - 2'd1;
            end
            2'b01: begin
                if (skid_count_r == 2'd0) begin
                    skid0_n_s = iRamDataOut;
                end else begin
                    skid1_n_s = iRamDataOut;
                end
                skid_count_n_s = skid_count_r + 2'd1;
            end
            2'b11: begin
                if (skid_count_r == 2'd1) begin
                    skid0_n_s = iRamDataOut;
                end else begin
                    skid0_n_s = skid1_r;
                    skid1_n_s = iRamDataOut;
                end
            end
            default: begin
                skid_count_n_s = skid_count_r;
            end
        endcase
    end

    // Pointer, count, skid and sticky-overflow state.
    always_ff @(posedge Clock or negedge iReset_n) begin
        if (!iReset_n) begin
            wr_ptr_r     <= ADDR_WIDTH'(1'b0);
            rd_ptr_r     <= ADDR_WIDTH'(1'b0);
            ram_cnt_r    <= (ADDR_WIDTH + 1)'(1'b0);
            inflight_r   <= 1'b0;
            skid_count_r <= 2'd0;
            skid0_r      <= DATA_WIDTH'(1'b0);
            skid1_r      <= DATA_WIDTH'(1'b0);
            overflow_r   <= 1'b0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (issue_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            ram_cnt_r    <= ram_cnt_n_s;
            inflight_r   <= issue_s;
            skid_count_r <= skid_count_n_s;
            skid0_r      <= skid0_n_s;
            skid1_r      <= skid1_n_s;
            overflow_r   <= overflow_r | (iPushValid & ~push_ready_s);
        end
    end

    assign oPushReady       = push_ready_s;
    assign oRamWriteEnable  = push_fire_s;
    assign oRamWriteAddress = wr_ptr_r;
    assign oRamDataIn       = iPushData;
    assign oRamReadAddress  = rd_ptr_r;
    assign oPopValid        = pop_valid_s;
    assign oPopData         = skid0_r;
    assign oOverflow        = overflow_r;
    assign oCount           = {1'b0, ram_cnt_r} + {{(ADDR_WIDTH + 1){1'b0}}, inflight_r}
                                                + {{ADDR_WIDTH{1'b0}}, skid_count_r};

endmodule
